// File: rtl/cop0_exc_ctrl.sv
// cop0_exc_ctrl - exception/interrupt sequencer for coprocessor 0.
//
// Samples EX-stage exception flags, pending interrupts and cop0 status bits
// while idle. It selects one winning event and then runs a fixed sequence:
// FLUSH (kill the pipeline), COMMIT or RET (cop0 state update), and
// REDIRECT (load the new PC).
//
// Optional build macro: COP0_TIMER_INT_EN adds a count/compare timer whose
// pending flag is ORed into cop_ip[7]. That build also adds the ports
// cmp_wr, cmp_wdata and count_out.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ex_valid, ex_pc, ex_bd      EX instruction valid, its PC, delay-slot flag
//   ex_ri/ov/sys/brk/eret       EX exception / eret flags
//   hard_int, sw_ip             hardware lines (level) and software pending bits
//   status_im/ie/exl/erl/bev    cop0 STATUS fields
//   epc_in, error_epc_in        current cop0 EPC / ERROR_EPC
//   busy, flush                 sequence active / kill IF-ID-EX
//   cop_wr, cop_epc_wr          cop0 exception record strobe / EPC+BD update
//   cop_exc_code, cop_epc, cop_bd  values written to cop0
//   cop_ip                      CAUSE[15:8] pending bits
//   cop_clr_exl, cop_clr_erl    eret strobes
//   pc_redirect, redirect_pc    PC load strobe and target
module cop0_exc_ctrl #(
    parameter logic [31:0] EXCEPTION_ENTRY = 32'h8000_0180,
    parameter logic [31:0] BOOT_ENTRY      = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_bd,
    input  logic        ex_ri,
    input  logic        ex_ov,
    input  logic        ex_sys,
    input  logic        ex_brk,
    input  logic        ex_eret,
    input  logic [5:0]  hard_int,
    input  logic [1:0]  sw_ip,
    input  logic [7:0]  status_im,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic        status_erl,
    input  logic        status_bev,
    input  logic [31:0] epc_in,
    input  logic [31:0] error_epc_in,
`ifdef COP0_TIMER_INT_EN
    input  logic        cmp_wr,
    input  logic [31:0] cmp_wdata,
    output logic [31:0] count_out,
`endif
    output logic        busy,
    output logic        flush,
    output logic        cop_wr,
    output logic        cop_epc_wr,
    output logic [4:0]  cop_exc_code,
    output logic [31:0] cop_epc,
    output logic        cop_bd,
    output logic [7:0]  cop_ip,
    output logic        cop_clr_exl,
    output logic        cop_clr_erl,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        COMMIT   = 3'd2,
        RET      = 3'd3,
        REDIRECT = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [5:0]  hard_int_r;
    logic [4:0]  code_r;
    logic        eret_r;
    logic        bd_r;
    logic [31:0] epc_r;
    logic        epc_wr_r;
    logic [31:0] target_r;

    logic        ip7_s;
    logic        int_ok_s;
    logic        evt_s;
    logic        evt_eret_s;
    logic [4:0]  evt_code_s;
    logic        accept_s;

`ifdef COP0_TIMER_INT_EN
    logic        tick_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        pending_r;

    // Timer: count advances every second clock; compare match raises pending
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r    <= 1'b0;
            count_r   <= 32'd0;
            compare_r <= 32'd0;
            pending_r <= 1'b0;
        end else begin
            tick_r <= ~tick_r;
            if (tick_r) begin
                count_r <= count_r + 32'd1;
            end
            // A compare write both reloads and acknowledges the timer
            if (cmp_wr) begin
                compare_r <= cmp_wdata;
                pending_r <= 1'b0;
            end else if (count_r == compare_r) begin
                pending_r <= 1'b1;
            end
        end
    end

    assign count_out = count_r;
    assign ip7_s     = hard_int_r[5] | pending_r;
`else
    assign ip7_s     = hard_int_r[5];
`endif

    assign cop_ip   = {ip7_s, hard_int_r[4:0], sw_ip};
    assign int_ok_s = status_ie & ~status_exl & ~status_erl & (|(cop_ip & status_im));

    // Event priority: interrupt, RI, OV, SYS, BP, ERET; lower flags are dropped
    always_comb begin
        evt_s      = 1'b1;
        evt_eret_s = 1'b0;
        evt_code_s = 5'h00;
        if (int_ok_s) begin
            evt_code_s = 5'h00;
        end else if (ex_ri) begin
            evt_code_s = 5'h0A;
        end else if (ex_ov) begin
            evt_code_s = 5'h0C;
        end else if (ex_sys) begin
            evt_code_s = 5'h08;
        end else if (ex_brk) begin
            evt_code_s = 5'h09;
        end else if (ex_eret) begin
            evt_eret_s = 1'b1;
        end else begin
            evt_s = 1'b0;
        end
    end

    assign accept_s = (state_r == IDLE) & ex_valid & evt_s;

    // Next-state logic for the flush/update/redirect sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:     state_s = accept_s ? FLUSH : IDLE;
            FLUSH:    state_s = eret_r ? RET : COMMIT;
            COMMIT:   state_s = REDIRECT;
            RET:      state_s = REDIRECT;
            REDIRECT: state_s = IDLE;
            default:  state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Event latch, interrupt-line sync and redirect target capture
    always_ff @(posedge clk) begin
        if (rst) begin
            hard_int_r <= 6'd0;
            code_r     <= 5'd0;
            eret_r     <= 1'b0;
            bd_r       <= 1'b0;
            epc_r      <= 32'd0;
            epc_wr_r   <= 1'b0;
            target_r   <= 32'd0;
        end else begin
            hard_int_r <= hard_int;
            if (accept_s) begin
                code_r   <= evt_code_s;
                eret_r   <= evt_eret_s;
                bd_r     <= ex_bd;
                epc_r    <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
                // A nested exception (EXL already set) must keep the old EPC
                epc_wr_r <= ~status_exl;
            end
            if (state_r == COMMIT) begin
                target_r <= status_bev ? BOOT_ENTRY : EXCEPTION_ENTRY;
            end else if (state_r == RET) begin
                target_r <= status_erl ? error_epc_in : epc_in;
            end else begin
                target_r <= target_r;
            end
        end
    end

    // Output decode from the state register and latched event
    always_comb begin
        busy         = 1'b0;
        flush        = 1'b0;
        cop_wr       = 1'b0;
        cop_epc_wr   = 1'b0;
        cop_exc_code = 5'd0;
        cop_epc      = 32'd0;
        cop_bd       = 1'b0;
        cop_clr_exl  = 1'b0;
        cop_clr_erl  = 1'b0;
        pc_redirect  = 1'b0;
        redirect_pc  = 32'd0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            FLUSH: begin
                busy  = 1'b1;
                flush = 1'b1;
            end
            COMMIT: begin
                busy         = 1'b1;
                cop_wr       = 1'b1;
                cop_epc_wr   = epc_wr_r;
                cop_exc_code = code_r;
                cop_epc      = epc_r;
                cop_bd       = bd_r;
            end
            RET: begin
                busy        = 1'b1;
                cop_clr_erl = status_erl;
                cop_clr_exl = ~status_erl;
            end
            REDIRECT: begin
                busy        = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = target_r;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cop0_exc_ctrl.sv
// Self-checking bench for cop0_exc_ctrl.
// A cycle-indexed expectation table is filled from the event rules: an
// accepted event at cycle c produces flush at c+1, the cop0 update at c+2
// and the redirect at c+3. A compare process checks every cycle. The
// directed tests also pin literal values.
module tb_cop0_exc_ctrl;
    localparam logic [31:0] EXC_V  = 32'h8000_0180;
    localparam logic [31:0] BOOT_V = 32'hBFC0_0380;
    localparam int          NCYC   = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_bd, ex_ri, ex_ov, ex_sys, ex_brk, ex_eret;
    logic [31:0] ex_pc, epc_in, error_epc_in;
    logic [5:0]  hard_int;
    logic [1:0]  sw_ip;
    logic [7:0]  status_im;
    logic        status_ie, status_exl, status_erl, status_bev;
    logic        busy, flush, cop_wr, cop_epc_wr, cop_bd, cop_clr_exl, cop_clr_erl, pc_redirect;
    logic [4:0]  cop_exc_code;
    logic [31:0] cop_epc, redirect_pc;
    logic [7:0]  cop_ip;
`ifdef COP0_TIMER_INT_EN
    logic        cmp_wr;
    logic [31:0] cmp_wdata, count_out;
`endif

    cop0_exc_ctrl dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_bd(ex_bd),
        .ex_ri(ex_ri), .ex_ov(ex_ov), .ex_sys(ex_sys), .ex_brk(ex_brk), .ex_eret(ex_eret),
        .hard_int(hard_int), .sw_ip(sw_ip), .status_im(status_im), .status_ie(status_ie),
        .status_exl(status_exl), .status_erl(status_erl), .status_bev(status_bev),
        .epc_in(epc_in), .error_epc_in(error_epc_in),
`ifdef COP0_TIMER_INT_EN
        .cmp_wr(cmp_wr), .cmp_wdata(cmp_wdata), .count_out(count_out),
`endif
        .busy(busy), .flush(flush), .cop_wr(cop_wr), .cop_epc_wr(cop_epc_wr),
        .cop_exc_code(cop_exc_code), .cop_epc(cop_epc), .cop_bd(cop_bd), .cop_ip(cop_ip),
        .cop_clr_exl(cop_clr_exl), .cop_clr_erl(cop_clr_erl),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy, flush, cop_wr, epc_wr;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd, clr_exl, clr_erl, redirect;
        logic [31:0] rpc;
    } exp_t;

    exp_t       exp_q [NCYC];
    int         cyc = 0;
    int         next_free = 0;
    logic [5:0] hi_prev = 6'd0;
    int         checks = 0;
    int         errors = 0;
    logic       done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: decides the winner and schedules the visible effects
    always @(posedge clk) begin
        logic [5:0] flg;
        logic [4:0] codes [6];
        logic       ok;
        int         w;
        exp_t       e;
        codes[0] = 5'h00; codes[1] = 5'h0A; codes[2] = 5'h0C;
        codes[3] = 5'h08; codes[4] = 5'h09; codes[5] = 5'h00;
        if (rst) begin
            for (int k = cyc + 1; k < NCYC; k++) exp_q[k] = '0;
            next_free = cyc + 1;
            hi_prev   = 6'd0;
        end else begin
            ok  = status_ie && !status_exl && !status_erl && ((({hi_prev, sw_ip}) & status_im) != 8'd0);
            flg = {ok, ex_ri, ex_ov, ex_sys, ex_brk, ex_eret};
            w = -1;
            for (int i = 0; i < 6; i++) if (w < 0 && flg[5-i]) w = i;
            if (ex_valid && w >= 0 && cyc >= next_free && cyc + 3 < NCYC) begin
                next_free = cyc + 4;
                e = '0; e.busy = 1'b1; e.flush = 1'b1;
                exp_q[cyc+1] = e;
                e = '0; e.busy = 1'b1;
                if (w == 5) begin
                    e.clr_erl = status_erl;
                    e.clr_exl = !status_erl;
                end else begin
                    e.cop_wr = 1'b1;
                    e.epc_wr = !status_exl;
                    e.code   = codes[w];
                    e.bd     = ex_bd;
                    e.epc    = ex_bd ? ex_pc - 32'd4 : ex_pc;
                end
                exp_q[cyc+2] = e;
                e = '0; e.busy = 1'b1; e.redirect = 1'b1;
                if (w == 5) e.rpc = status_erl ? error_epc_in : epc_in;
                else        e.rpc = status_bev ? BOOT_V : EXC_V;
                exp_q[cyc+3] = e;
            end
            hi_prev = hard_int;
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NCYC && !done) begin
            chk("busy", {31'd0, busy}, {31'd0, exp_q[cyc].busy});
            chk("flush", {31'd0, flush}, {31'd0, exp_q[cyc].flush});
            chk("cop_wr", {31'd0, cop_wr}, {31'd0, exp_q[cyc].cop_wr});
            chk("cop_epc_wr", {31'd0, cop_epc_wr}, {31'd0, exp_q[cyc].epc_wr});
            chk("cop_exc_code", {27'd0, cop_exc_code}, {27'd0, exp_q[cyc].code});
            chk("cop_epc", cop_epc, exp_q[cyc].epc);
            chk("cop_bd", {31'd0, cop_bd}, {31'd0, exp_q[cyc].bd});
            chk("cop_clr_exl", {31'd0, cop_clr_exl}, {31'd0, exp_q[cyc].clr_exl});
            chk("cop_clr_erl", {31'd0, cop_clr_erl}, {31'd0, exp_q[cyc].clr_erl});
            chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, exp_q[cyc].redirect});
            chk("redirect_pc", redirect_pc, exp_q[cyc].rpc);
`ifdef COP0_TIMER_INT_EN
            chk("cop_ip", {25'd0, cop_ip[6:0]}, {25'd0, hi_prev[4:0], sw_ip});
`else
            chk("cop_ip", {24'd0, cop_ip}, {24'd0, hi_prev, sw_ip});
`endif
        end
    end

    // kind: 0 exception, 1 eret clearing EXL, 2 eret clearing ERL
    task automatic fire(input string nm, input logic [4:0] f, input logic bd, input logic [31:0] pc,
                        input int kind, input logic [4:0] code, input logic [31:0] epc,
                        input logic epc_wr, input logic [31:0] rpc);
        @(posedge clk); #2;
        ex_valid = 1'b1; {ex_ri, ex_ov, ex_sys, ex_brk, ex_eret} = f; ex_bd = bd; ex_pc = pc;
        @(posedge clk); #2;
        ex_valid = 1'b0; {ex_ri, ex_ov, ex_sys, ex_brk, ex_eret} = 5'd0; ex_bd = 1'b0;
        @(negedge clk);
        chk({nm, ".flush"}, {31'd0, flush}, 32'd1);
        @(negedge clk);
        if (kind == 0) begin
            chk({nm, ".cop_wr"}, {31'd0, cop_wr}, 32'd1);
            chk({nm, ".code"}, {27'd0, cop_exc_code}, {27'd0, code});
            chk({nm, ".epc"}, cop_epc, epc);
            chk({nm, ".bd"}, {31'd0, cop_bd}, {31'd0, bd});
            chk({nm, ".epc_wr"}, {31'd0, cop_epc_wr}, {31'd0, epc_wr});
        end else begin
            chk({nm, ".clr_exl"}, {31'd0, cop_clr_exl}, (kind == 1) ? 32'd1 : 32'd0);
            chk({nm, ".clr_erl"}, {31'd0, cop_clr_erl}, (kind == 2) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk({nm, ".pc_redirect"}, {31'd0, pc_redirect}, 32'd1);
        chk({nm, ".redirect_pc"}, redirect_pc, rpc);
    endtask

    initial begin
        for (int k = 0; k < NCYC; k++) exp_q[k] = '0;
        rst = 1'b1; ex_valid = 1'b0; ex_pc = 32'd0; ex_bd = 1'b0;
        {ex_ri, ex_ov, ex_sys, ex_brk, ex_eret} = 5'd0;
        hard_int = 6'd0; sw_ip = 2'd0; status_im = 8'd0;
        status_ie = 1'b0; status_exl = 1'b0; status_erl = 1'b0; status_bev = 1'b0;
        epc_in = 32'd0; error_epc_in = 32'd0;
`ifdef COP0_TIMER_INT_EN
        cmp_wr = 1'b0; cmp_wdata = 32'd0;
`endif
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
`ifdef COP0_TIMER_INT_EN
        cmp_wr = 1'b1; cmp_wdata = 32'd4;
        @(posedge clk); #2 cmp_wr = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("timer.count", count_out, 32'd6);
        chk("timer.ip7_set", {31'd0, cop_ip[7]}, 32'd1);
        @(posedge clk); #2 cmp_wr = 1'b1; cmp_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #2 cmp_wr = 1'b0;
        @(negedge clk);
        chk("timer.ip7_clr", {31'd0, cop_ip[7]}, 32'd0);
`endif
        @(negedge clk);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.cop_ip", {24'd0, cop_ip}, 32'd0);

        fire("sys", 5'b00100, 1'b0, 32'h0040_0010, 0, 5'h08, 32'h0040_0010, 1'b1, 32'h8000_0180);
        status_bev = 1'b1;
        fire("ov_bd_bev", 5'b01000, 1'b1, 32'h0040_0024, 0, 5'h0C, 32'h0040_0020, 1'b1, 32'hBFC0_0380);
        status_bev = 1'b0;

        hard_int = 6'b000001; status_im = 8'h04; status_ie = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("int.cop_ip", {24'd0, cop_ip}, 32'h0000_0004);
        fire("int_wins", 5'b00100, 1'b0, 32'h0040_0040, 0, 5'h00, 32'h0040_0040, 1'b1, 32'h8000_0180);

        status_exl = 1'b1;
        @(posedge clk); #2 ex_valid = 1'b1;
        @(posedge clk); #2 ex_valid = 1'b0;
        @(negedge clk);
        chk("int_blocked.busy", {31'd0, busy}, 32'd0);
        fire("brk_nested", 5'b00010, 1'b0, 32'h0040_0050, 0, 5'h09, 32'h0040_0050, 1'b0, 32'h8000_0180);
        status_exl = 1'b0; status_ie = 1'b0; hard_int = 6'd0; status_im = 8'd0;

        epc_in = 32'h0040_0100;
        fire("eret_exl", 5'b00001, 1'b0, 32'h0040_0060, 1, 5'h00, 32'd0, 1'b0, 32'h0040_0100);
        status_erl = 1'b1; error_epc_in = 32'hBFC0_0000;
        fire("eret_erl", 5'b00001, 1'b0, 32'h0040_0070, 2, 5'h00, 32'd0, 1'b0, 32'hBFC0_0000);
        status_erl = 1'b0;

        fire("ri_over_ov_wrap", 5'b11000, 1'b1, 32'h0000_0000, 0, 5'h0A, 32'hFFFF_FFFC, 1'b1, 32'h8000_0180);

        sw_ip = 2'b10;
        @(posedge clk); #2 ex_sys = 1'b1;
        @(posedge clk); #2 ex_sys = 1'b0;
        @(negedge clk);
        chk("no_valid.busy", {31'd0, busy}, 32'd0);
        chk("sw_ip.cop_ip", {24'd0, cop_ip}, 32'h0000_0002);
        sw_ip = 2'b00;

        @(posedge clk); #2 ex_valid = 1'b1; ex_sys = 1'b1; ex_pc = 32'h0040_0080;
        @(posedge clk); #2 ex_valid = 1'b0; ex_sys = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.cop_wr_before", {31'd0, cop_wr}, 32'd1);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.busy", {31'd0, busy}, 32'd0);
        chk("rst_mid.pc_redirect", {31'd0, pc_redirect}, 32'd0);
        chk("rst_mid.cop_wr", {31'd0, cop_wr}, 32'd0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
